// File: rtl/sdram_write_pkg.sv
// Shared widths, mask constant and arbiter state encoding for the SDRAM write path.
package sdram_write_pkg;
  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MASK_WIDTH = 4;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/write_request_slot.sv
// One requester's latch: captures a write pulse, holds it until the arbiter
// retires it, and flags pulses that arrive while the slot is still occupied.
module write_request_slot
  import sdram_write_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DEF_MASK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [MASK_WIDTH-1:0] mask_i,
  input  logic                  clear_i,
  output logic                  pending_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [MASK_WIDTH-1:0] mask_o,
  output logic                  overrun_o
);
  logic                  pending_q;
  logic                  overrun_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [MASK_WIDTH-1:0] mask_q;

  // clear_i only arrives while pending, and a pulse while pending is dropped,
  // so capture and clear never compete for the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '1;
    end else begin
      overrun_q <= req_i & pending_q;
      if (req_i && !pending_q) begin
        pending_q <= 1'b1;
        addr_q    <= addr_i;
        data_q    <= data_i;
        mask_q    <= mask_i;
      end else if (clear_i) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending_o = pending_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign mask_o    = mask_q;
  assign overrun_o = overrun_q;
endmodule

// File: rtl/sdram_write_arbiter.sv
// Shares the SDRAM write port among REQUESTERS cell writers, one write in flight.
// Define SDRAM_ARBITER_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
module sdram_write_arbiter
  import sdram_write_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DEF_MASK_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_wr_address,
  input  logic [REQUESTERS-1:0]            req_wr_request,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_wr_data,
  input  logic [REQUESTERS*MASK_WIDTH-1:0] req_wr_mask,
  output logic [REQUESTERS-1:0]            req_wr_done,
  output logic [ADDR_WIDTH-1:0]            sdram_wr_address,
  output logic                             sdram_wr_request,
  output logic [DATA_WIDTH-1:0]            sdram_wr_data,
  output logic [MASK_WIDTH-1:0]            sdram_wr_mask,
  input  logic                             sdram_wr_done,
  output logic [REQUESTERS-1:0]            overrun
);
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]                 pending;
  logic [REQUESTERS-1:0]                 clear;
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] slot_addr;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] slot_data;
  logic [REQUESTERS-1:0][MASK_WIDTH-1:0] slot_mask;

  for (genvar i = 0; i < REQUESTERS; i++) begin : g_slot
    write_request_slot #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .MASK_WIDTH(MASK_WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_i    (req_wr_request[i]),
      .addr_i   (req_wr_address[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .data_i   (req_wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .mask_i   (req_wr_mask[i*MASK_WIDTH +: MASK_WIDTH]),
      .clear_i  (clear[i]),
      .pending_o(pending[i]),
      .addr_o   (slot_addr[i]),
      .data_o   (slot_data[i]),
      .mask_o   (slot_mask[i]),
      .overrun_o(overrun[i])
    );
  end

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic [REQUESTERS-1:0] done_q, done_d;

  logic          found;
  logic [PW-1:0] gnt;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
`ifdef SDRAM_ARBITER_PRIORITY_EN
    for (int k = REQUESTERS-1; k >= 0; k--) begin
      if (pending[PW'(k)]) begin
        found = 1'b1;
        gnt   = PW'(k);
      end
    end
`else
    // first pending slot at or after the pointer, wrapping
    for (int k = 0; k < REQUESTERS; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!found && pending[PW'(idx)]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    done_d  = '0;
    clear   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          owner_d = gnt;
          req_d   = 1'b1;
          addr_d  = slot_addr[gnt];
          data_d  = slot_data[gnt];
          mask_d  = slot_mask[gnt];
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (sdram_wr_done) begin
          clear[owner_q]  = 1'b1;
          done_d[owner_q] = 1'b1;
          ptr_d   = (int'(owner_q) == REQUESTERS-1) ? '0 : owner_q + PW'(1);
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '1;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  assign sdram_wr_request = req_q;
  assign sdram_wr_address = addr_q;
  assign sdram_wr_data    = data_q;
  assign sdram_wr_mask    = mask_q;
  assign req_wr_done      = done_q;
endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Randomized and directed bench for sdram_write_arbiter against a transaction-level model.
// Honours SDRAM_ARBITER_PRIORITY_EN the same way as the design.
module tb_sdram_write_arbiter;
  import sdram_write_pkg::*;

  localparam int R  = 2;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [R*AW-1:0] req_wr_address;
  logic [R-1:0]    req_wr_request;
  logic [R*DW-1:0] req_wr_data;
  logic [R*MW-1:0] req_wr_mask;
  logic [R-1:0]    req_wr_done;
  logic [AW-1:0]   sdram_wr_address;
  logic            sdram_wr_request;
  logic [DW-1:0]   sdram_wr_data;
  logic [MW-1:0]   sdram_wr_mask;
  logic            sdram_wr_done;
  logic [R-1:0]    overrun;

  sdram_write_arbiter #(.REQUESTERS(R), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_wr_address  (req_wr_address),
    .req_wr_request  (req_wr_request),
    .req_wr_data     (req_wr_data),
    .req_wr_mask     (req_wr_mask),
    .req_wr_done     (req_wr_done),
    .sdram_wr_address(sdram_wr_address),
    .sdram_wr_request(sdram_wr_request),
    .sdram_wr_data   (sdram_wr_data),
    .sdram_wr_mask   (sdram_wr_mask),
    .sdram_wr_done   (sdram_wr_done),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model: what each requester has outstanding and what the SDRAM side should see
  logic [R-1:0]  m_pend;
  logic [AW-1:0] m_addr [R];
  logic [DW-1:0] m_data [R];
  logic [MW-1:0] m_mask [R];
  logic          m_busy;
  int            m_owner, m_ptr;
  logic          exp_req;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [MW-1:0] exp_mask;
  logic [R-1:0]  exp_done, exp_ovr;

  int  cnt = 0, lat = 3;
  bit  rand_lat = 1'b0;
  int  t_req, t_done, n_sreq;
  int  n_dn [R];
  int  n_ovr [R];
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_wr_request[i] = 1'b1;
    req_wr_address[i*AW +: AW] = a;
    req_wr_data[i*DW +: DW] = d;
    req_wr_mask[i*MW +: MW] = m;
  endtask

  task automatic mreset();
    m_pend = '0; m_busy = 1'b0; m_owner = 0; m_ptr = 0;
    for (int i = 0; i < R; i++) begin
      m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '1;
    end
    exp_req = 1'b0; exp_addr = '0; exp_data = '0; exp_mask = '1;
    exp_done = '0; exp_ovr = '0;
  endtask

  task automatic clr_stats();
    t_req = -1; t_done = -1; n_sreq = 0;
    for (int i = 0; i < R; i++) begin n_dn[i] = 0; n_ovr[i] = 0; end
    q_addr.delete(); q_data.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_adv();
    logic [R-1:0] p0;
    int sel;
    p0 = m_pend;
    exp_req = 1'b0; exp_done = '0; exp_ovr = '0;
    if (!m_busy && (p0 != '0)) begin
      sel = -1;
`ifdef SDRAM_ARBITER_PRIORITY_EN
      for (int k = 0; k < R; k++) if (sel < 0 && p0[k]) sel = k;
`else
      for (int k = 0; k < R; k++) if (sel < 0 && p0[(m_ptr + k) % R]) sel = (m_ptr + k) % R;
`endif
      exp_req = 1'b1; exp_addr = m_addr[sel]; exp_data = m_data[sel]; exp_mask = m_mask[sel];
      m_busy = 1'b1; m_owner = sel;
    end else if (m_busy && sdram_wr_done) begin
      exp_done[m_owner] = 1'b1;
      m_pend[m_owner] = 1'b0;
      m_busy = 1'b0;
      m_ptr = (m_owner + 1) % R;
    end
    for (int i = 0; i < R; i++) begin
      if (req_wr_request[i]) begin
        if (p0[i]) exp_ovr[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_addr[i] = req_wr_address[i*AW +: AW];
          m_data[i] = req_wr_data[i*DW +: DW];
          m_mask[i] = req_wr_mask[i*MW +: MW];
        end
      end
    end
  endtask

  // One clock: SDRAM responder, model update, then compare at the negedge.
  task automatic step();
    sdram_wr_done = 1'b0;
    if (exp_req) cnt = rand_lat ? int'($urandom_range(1, 6)) : lat;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) sdram_wr_done = 1'b1;
    end
    model_adv();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("sdram_req",  sdram_wr_request, exp_req);
    chk("sdram_addr", sdram_wr_address, exp_addr);
    chk("sdram_data", sdram_wr_data,    exp_data);
    chk("sdram_mask", sdram_wr_mask,    exp_mask);
    chk("req_done",   req_wr_done,      exp_done);
    chk("overrun",    overrun,          exp_ovr);
    if (sdram_wr_request) begin
      n_sreq++;
      q_addr.push_back(sdram_wr_address);
      q_data.push_back(sdram_wr_data);
      if (t_req < 0) t_req = cyc;
    end
    for (int i = 0; i < R; i++) begin
      if (req_wr_done[i]) n_dn[i]++;
      if (overrun[i]) n_ovr[i]++;
    end
    if (req_wr_done[0] && t_done < 0) t_done = cyc;
    req_wr_request = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req",  sdram_wr_request, 1'b0);
    chk("rst_addr", sdram_wr_address, '0);
    chk("rst_data", sdram_wr_data,    '0);
    chk("rst_mask", sdram_wr_mask,    MASK_ALL);
    chk("rst_done", req_wr_done,      '0);
    chk("rst_ovr",  overrun,          '0);
    mreset();
    cnt = 0;
    req_wr_request = '0;
    sdram_wr_done  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int k0, k1, rem0, rem1, guard;
    reset_n = 1'b1;
    req_wr_request = '0; req_wr_address = '0; req_wr_data = '0; req_wr_mask = '0;
    sdram_wr_done = 1'b0;
    mreset();
    @(negedge clk);
    do_reset();

    // single requester with fixed latency
    clr_stats(); lat = 5; rand_lat = 1'b0;
    while (cyc < 10) step();
    put(0, 23'h000140, 32'h0F001020, 4'b1111);
    while (cyc < 22) step();
    chk("t1_req_cyc",  64'(t_req), 64'd12);
    chk("t1_done_cyc", 64'(t_done), 64'd18);
    chk("t1_addr", (q_addr.size() > 0) ? 64'(q_addr[0]) : 64'hX, 64'h000140);
    chk("t1_data", (q_data.size() > 0) ? 64'(q_data[0]) : 64'hX, 64'h0F001020);

    // simultaneous requests from pointer 0
    do_reset(); clr_stats(); lat = 3;
    put(0, 23'h000AA0, 32'hAAAA0000, 4'b0001);
    put(1, 23'h000BB0, 32'hBBBB1111, 4'b1000);
    repeat (20) step();
    chk("sim_nreq", 64'(n_sreq), 64'd2);
    chk("sim_addr0", (q_addr.size() > 1) ? 64'(q_addr[0]) : 64'hX, 64'h000AA0);
    chk("sim_addr1", (q_addr.size() > 1) ? 64'(q_addr[1]) : 64'hX, 64'h000BB0);
    chk("sim_data1", (q_data.size() > 1) ? 64'(q_data[1]) : 64'hX, 64'hBBBB1111);
    chk("sim_done0", 64'(n_dn[0]), 64'd1);
    chk("sim_done1", 64'(n_dn[1]), 64'd1);

    // fairness: both re-request in the cycle their done is seen
    do_reset(); clr_stats(); lat = 2;
    put(0, 23'h000100, 32'h1000, 4'hF);
    put(1, 23'h000200, 32'h2000, 4'hF);
    k0 = 1; k1 = 1;
    repeat (40) begin
      step();
      if (exp_done[0] && k0 < 4) begin put(0, AW'(32'h100 + k0), 32'h1000 + k0, 4'hF); k0++; end
      if (exp_done[1] && k1 < 4) begin put(1, AW'(32'h200 + k1), 32'h2000 + k1, 4'hF); k1++; end
    end
    chk("fair_n", 64'(q_addr.size() >= 4), 64'd1);
    for (int j = 0; j < 4; j++)
      chk("fair_order", (q_addr.size() > j) ? 64'(q_addr[j]) : 64'hX,
          64'(((j % 2) == 0 ? 32'h100 : 32'h200) + j / 2));

    // overrun: second pulse while still pending is dropped
    clr_stats(); lat = 6;
    put(1, 23'h000321, 32'h11112222, 4'b0011);
    repeat (3) step();
    put(1, 23'h000322, 32'hDEADBEEF, 4'b1111);
    repeat (15) step();
    chk("ovr_cnt",   64'(n_ovr[1]), 64'd1);
    chk("ovr_done",  64'(n_dn[1]), 64'd1);
    chk("ovr_nreq",  64'(q_data.size()), 64'd1);
    chk("ovr_data",  (q_data.size() > 0) ? 64'(q_data[0]) : 64'hX, 64'h11112222);

    // reset in the middle of a write
    clr_stats(); lat = 6;
    put(0, 23'h000777, 32'h77777777, 4'hF);
    repeat (4) step();
    chk("mid_busy", 64'(m_busy), 64'd1);
    do_reset(); clr_stats();
    repeat (10) step();
    chk("mid_nodone", 64'(n_dn[0]), 64'd0);
    put(0, 23'h000778, 32'h78787878, 4'hF);
    repeat (12) step();
    chk("mid_after", 64'(n_dn[0]), 64'd1);

    // random traffic including overruns
    rand_lat = 1'b1;
    repeat (1500) begin
      for (int i = 0; i < R; i++)
        if ($urandom_range(0, 3) == 0) put(i, AW'($urandom), $urandom, MW'($urandom));
      step();
    end
    repeat (30) step();

    // clear-screen stress
    clr_stats(); rand_lat = 1'b0; lat = 1;
    rem0 = 4080; rem1 = 10; k0 = 0; k1 = 0; guard = 0;
    while ((rem0 > 0 || rem1 > 0 || m_busy || m_pend != '0) && guard < 40000) begin
      if (rem0 > 0 && !m_pend[0]) begin put(0, AW'(k0 * 4), $urandom, 4'hF); k0++; rem0--; end
      if (rem1 > 0 && !m_pend[1] && $urandom_range(0, 99) == 0) begin
        put(1, AW'(32'h400000 + k1), $urandom, 4'hF); k1++; rem1--;
      end
      step();
      guard++;
    end
    repeat (3) step();
    chk("stress_guard", 64'(guard < 40000), 64'd1);
    chk("stress_nreq",  64'(n_sreq), 64'd4090);
    chk("stress_done0", 64'(n_dn[0]), 64'd4080);
    chk("stress_done1", 64'(n_dn[1]), 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
